i2c_reg_responder: RTL
======================

Name: i2c_reg_responder

Overview:
- I2C target (responder) for the on-board I2C master that drives SDA_BUS/SCL_BUS on the LC3 memory-mapped I/O path.
- Exposes a 16 x 8-bit register file over the bus, with an auto-incrementing pointer.
- Gives the FPGA fabric a local read port and a write-event strobe.
- Serves as both a loopback target for the LC3 I2C driver software and an on-chip peripheral.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this block answers to.

Ports:
- clk  input  1  system clock; must run at 16x the SCL frequency or faster.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock. This block never drives or stretches it.
- sda  inout  1  I2C data, open-drain. Driven 0 when sda_oe=1, otherwise 1'bz.
- rd_addr  input  4  local register read index.
- rd_data  output  8  combinational read of reg[rd_addr].
- wr_stb  output  1  one-cycle pulse when the bus master writes a register.
- wr_idx  output  4  register index written; valid with wr_stb.
- wr_val  output  8  data written; valid with wr_stb.
- busy  output  1  high from an address-matched START until STOP or the next START.

Behaviour:
- Reset (async, rst=1):
  - all regs=0, pointer=0, state=IDLE, sda_oe=0 (sda released).
  - wr_stb=0, wr_idx=0, wr_val=0, busy=0.
  - Reset mid-transfer releases sda immediately.
- Input sync:
  - scl and sda each pass through 2 flops; edges are detected on the synchronized values.
  - Internal latency is 3 clk from a pin change to the detected edge.
- START: synced sda falls while scl is high. From any state: go to ADDR, clear the bit counter, release sda.
- Repeated START is handled identically; the pointer is kept.
- STOP: synced sda rises while scl is high. From any state: go to IDLE, busy=0, release sda.
- Sampling and driving:
  - sda is sampled on scl rising edges, MSB first.
  - This block changes sda only on scl falling edges.
- States:
  - IDLE: ignore the bus except START.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - After the 8th rise: if addr==SLAVE_ADDR go to ADDR_ACK, set busy=1, latch R/W.
    - Otherwise go to IDLE and stay silent until the next START.
  - ADDR_ACK: drive sda=0 on the falling edge after bit 8; release on the next falling edge.
    - R/W=0: go to WR_BYTE with first_byte=1.
    - R/W=1: go to RD_BYTE.
  - WR_BYTE: shift 8 bits, then go to WR_ACK. Always ACK (drive low for one SCL period).
    - If first_byte: pointer <= byte[3:0] (upper nibble ignored), first_byte=0.
    - Else: reg[pointer] <= byte, wr_stb pulses 1 clk with wr_idx=pointer and wr_val=byte, then pointer increments.
    - The register update and wr_stb occur on the clk that detects the 8th rising edge.
  - RD_BYTE:
    - On the falling edge that enters the state, load shift <= reg[pointer] and present bit7.
    - Shift out on each subsequent falling edge; sda_oe = ~current_bit.
    - After the 8th bit's falling edge, release sda and go to RD_ACK.
    - pointer increments when the byte is loaded.
  - RD_ACK: sample sda on the scl rise.
    - 0 (ACK): go to RD_BYTE.
    - 1 (NACK): go to WAIT and stay released until STOP/START.
- Pointer arithmetic: 4-bit, wraps 15 -> 0 on both read and write.
- Simultaneous events:
  - A local rd_addr read of the register being written returns the old value until the write clk, then the new value.
  - START/STOP detection takes priority over bit shifting in the same clk.

Test Plan:
- Reset with rst=1 mid-read while sda_oe=1 -> sda released within 0 clk, regs=0, busy=0.
- Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP (100 kHz SCL, 50 MHz clk) ->
  - three ACKs plus the address ACK;
  - wr_stb pulses twice, (3,0x5A) then (4,0xC3);
  - rd_addr=3 gives 0x5A and rd_addr=4 gives 0xC3.
- Read with repeated START: START, 0xA0, 0x03, rSTART, 0xA1, master ACK, master NACK, STOP -> bytes 0x5A, 0xC3 on sda, then sda released, busy=0.
- Wrap: write pointer 0x0F, data 0x11, 0x22 -> reg15=0x11, reg0=0x22.
- Address mismatch: START, 0x42 -> sda never driven, busy stays 0, later writes ignored until the next START; a following START with 0xA0 is ACKed.
- Pointer-only write: write pointer 0x1E -> pointer=0xE, no wr_stb; a subsequent read returns reg14.

Source files
------------

// File: rtl/i2c_reg_responder.sv
// I2C target exposing a 16 x 8-bit register file with an auto-incrementing pointer,
// plus a local combinational read port and a write-event strobe for the fabric.
module i2c_reg_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_stb,
    output logic [3:0] wr_idx,
    output logic [7:0] wr_val,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT} state_t;

    state_t     state;
    logic [7:0] regs [16];
    logic [3:0] ptr;
    logic [7:0] sh;
    logic [2:0] bit_cnt;
    logic       rw, first_byte, phase, sda_oe;
    logic [2:0] scl_sr, sda_sr;

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign rd_data = regs[rd_addr];

    // [1] is the synchronized level, [2] the previous one for edge detection
    wire scl_rise = scl_sr[1] & ~scl_sr[2];
    wire scl_fall = ~scl_sr[1] & scl_sr[2];
    wire scl_hi   = scl_sr[1] & scl_sr[2];
    wire start    = scl_hi & ~sda_sr[1] & sda_sr[2];
    wire stop     = scl_hi & sda_sr[1] & ~sda_sr[2];
    wire [7:0] sh_next = {sh[6:0], sda_sr[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sr     <= 3'b111;
            sda_sr     <= 3'b111;
            state      <= IDLE;
            ptr        <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            phase      <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_idx     <= '0;
            wr_val     <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            scl_sr <= {scl_sr[1:0], scl};
            sda_sr <= {sda_sr[1:0], sda};
            wr_stb <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                phase   <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                phase  <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        sh      <= sh_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (sh_next[7:1] == SLAVE_ADDR) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                                rw    <= sh_next[0];
                                phase <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    // phase 0: first fall pulls sda low; phase 1: next fall ends the ACK
                    ADDR_ACK, WR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw) begin
                                sh     <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                ptr    <= ptr + 4'd1;
                                state  <= RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_BYTE;
                                if (state == ADDR_ACK) first_byte <= 1'b1;
                            end
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        sh      <= sh_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= WR_ACK;
                            phase <= 1'b0;
                            if (first_byte) begin
                                ptr        <= sh_next[3:0];
                                first_byte <= 1'b0;
                            end else begin
                                regs[ptr] <= sh_next;
                                wr_stb    <= 1'b1;
                                wr_idx    <= ptr;
                                wr_val    <= sh_next;
                                ptr       <= ptr + 4'd1;
                            end
                        end
                    end
                    RD_BYTE: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe <= 1'b0;
                            state  <= RD_ACK;
                            phase  <= 1'b0;
                        end else begin
                            sh      <= {sh[6:0], 1'b0};
                            sda_oe  <= ~sh[6];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    // master ACK is seen on the rise; the next byte loads on the following fall
                    RD_ACK: if (scl_rise) begin
                        if (sda_sr[1]) state <= WAIT;
                        else phase <= 1'b1;
                    end else if (scl_fall && phase) begin
                        phase   <= 1'b0;
                        bit_cnt <= '0;
                        sh      <= regs[ptr];
                        sda_oe  <= ~regs[ptr][7];
                        ptr     <= ptr + 4'd1;
                        state   <= RD_BYTE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
